// File: rtl/sw_out_arbiter.sv
// Output-port arbiter for a mesh switch: five requesters compete round-robin for
// a single registered output slot that can drain and refill in the same cycle.
module sw_out_arbiter #(
    parameter int DATA_W = 24,
    parameter int NPORT  = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid_t,
    input  logic              i_valid_r,
    input  logic              i_valid_b,
    input  logic              i_valid_l,
    input  logic              i_valid_pe,
    input  logic [DATA_W-1:0] i_data_t,
    input  logic [DATA_W-1:0] i_data_r,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic [DATA_W-1:0] i_data_l,
    input  logic [DATA_W-1:0] i_data_pe,
    output logic              o_ready_t,
    output logic              o_ready_r,
    output logic              o_ready_b,
    output logic              o_ready_l,
    output logic              o_ready_pe,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [2:0]        o_grant_idx
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_ptr;

    logic [NPORT-1:0]  w_valid;
    logic [DATA_W-1:0] w_data [NPORT];
    logic [NPORT-1:0]  w_ready;
    logic              w_free;
    logic              w_req_any;
    logic              w_take;
    logic [2:0]        w_win;

    assign w_valid   = {i_valid_pe, i_valid_l, i_valid_b, i_valid_r, i_valid_t};
    assign w_data[0] = i_data_t;
    assign w_data[1] = i_data_r;
    assign w_data[2] = i_data_b;
    assign w_data[3] = i_data_l;
    assign w_data[4] = i_data_pe;

    function automatic logic [2:0] f_wrap(input logic [2:0] base, input int unsigned off);
        return 3'((32'(base) + off) % NPORT);
    endfunction

    // Walk the ring from farthest to nearest so the nearest valid requester after ptr wins.
    always_comb begin
        w_req_any = 1'b0;
        w_win     = r_ptr;
        for (int k = NPORT; k >= 1; k--) begin
            if (w_valid[f_wrap(r_ptr, k)]) begin
                w_req_any = 1'b1;
                w_win     = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_free = (r_state == S_EMPTY) || i_ready;
    // Gating with rstn keeps every grant low for the whole reset window.
    assign w_take = rstn && w_free && w_req_any;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_ready
            assign w_ready[gi] = w_take && (w_win == 3'(gi));
        end
    endgenerate

    assign o_ready_t  = w_ready[0];
    assign o_ready_r  = w_ready[1];
    assign o_ready_b  = w_ready[2];
    assign o_ready_l  = w_ready[3];
    assign o_ready_pe = w_ready[4];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_ptr   <= 3'd4;
        end else begin
            if (w_take) begin
                r_state <= S_FULL;
                r_data  <= w_data[w_win];
                r_ptr   <= w_win;
            end else if ((r_state == S_FULL) && i_ready) begin
                r_state <= S_EMPTY;
            end
        end
    end

    assign o_valid     = (r_state == S_FULL);
    assign o_data      = r_data;
    assign o_grant_idx = r_ptr;

endmodule
